// File: rtl/adsr_envelope.sv
// ADSR amplitude envelope with a built-in VCA.
// The envelope level steps once per sample tick. Gate edges switch phases
// and take priority over ticks. The registered level scales the incoming
// signed sample through a 16x17 signed multiply.
module adsr_envelope (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_tick,
  input  logic        i_gate,
  input  logic [15:0] i_attack_rate,
  input  logic [15:0] i_decay_rate,
  input  logic [15:0] i_sustain_level,
  input  logic [15:0] i_release_rate,
  input  logic [15:0] i_data,
  output logic [15:0] o_data,
  output logic [15:0] o_env,
  output logic [2:0]  o_state,
  output logic        o_busy
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [15:0]        r_env;
  logic [15:0]        w_env_next;
  logic               r_gate_q;
  logic [15:0]        r_data;

  logic               w_rise;
  logic               w_fall;
  logic [16:0]        w_attack_sum;
  logic [16:0]        w_decay_thr;
  logic signed [31:0] w_prod;

  assign w_rise = i_gate & ~r_gate_q;
  assign w_fall = ~i_gate & r_gate_q;

  // The widened sums keep the saturation and sustain compares free of wrap-around.
  assign w_attack_sum = {1'b0, r_env} + {1'b0, i_attack_rate};
  assign w_decay_thr  = {1'b0, i_sustain_level} + {1'b0, i_decay_rate};

  // The level is zero-extended so full scale stays positive. The product
  // always fits in 32 signed bits. The VCA reads the level held at the start
  // of the cycle.
  assign w_prod = $signed(i_data) * $signed({1'b0, r_env});

  // Compute the next phase and level. Gate events win, and a tick in the
  // same cycle is dropped.
  always_comb begin
    w_state_next = r_state;
    w_env_next   = r_env;
    case (r_state)
      ST_IDLE: begin
        w_env_next = 16'd0;
        if (w_rise) w_state_next = ST_ATTACK;
      end
      ST_ATTACK: begin
        if (w_fall) begin
          w_state_next = ST_RELEASE;
        end else if (i_tick) begin
          if (w_attack_sum >= 17'd65535) begin
            w_env_next   = 16'hFFFF;
            w_state_next = ST_DECAY;
          end else begin
            w_env_next = w_attack_sum[15:0];
          end
        end
      end
      ST_DECAY: begin
        if (w_fall) begin
          w_state_next = ST_RELEASE;
        end else if (i_tick) begin
          if ({1'b0, r_env} <= w_decay_thr) begin
            w_env_next   = i_sustain_level;
            w_state_next = ST_SUSTAIN;
          end else begin
            w_env_next = r_env - i_decay_rate;
          end
        end
      end
      ST_SUSTAIN: begin
        if (w_fall) begin
          w_state_next = ST_RELEASE;
        end else if (i_tick) begin
          w_env_next = i_sustain_level;
        end
      end
      ST_RELEASE: begin
        // A retrigger resumes the attack from the current level.
        if (w_rise) begin
          w_state_next = ST_ATTACK;
        end else if (i_tick) begin
          if (r_env <= i_release_rate) begin
            w_env_next   = 16'd0;
            w_state_next = ST_IDLE;
          end else begin
            w_env_next = r_env - i_release_rate;
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_env_next   = 16'd0;
      end
    endcase
  end

  // Register the state, level, gate history and the VCA output.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_env    <= 16'd0;
      r_gate_q <= 1'b0;
      r_data   <= 16'd0;
    end else begin
      r_state  <= w_state_next;
      r_env    <= w_env_next;
      r_gate_q <= i_gate;
      r_data   <= 16'(w_prod >>> 16);
    end
  end

  assign o_data  = r_data;
  assign o_env   = r_env;
  assign o_state = r_state;
  assign o_busy  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_adsr_envelope.sv
// Directed bench for adsr_envelope.
// A vector table covers one full ADSR cycle. Hand-written sequences cover
// reset, tick/gate collision, retrigger, VCA arithmetic and live sustain.
module tb_adsr_envelope;

  logic        clk;
  logic        rst;
  logic        tick;
  logic        gate;
  logic [15:0] attack_rate;
  logic [15:0] decay_rate;
  logic [15:0] sustain_level;
  logic [15:0] release_rate;
  logic [15:0] din;
  logic [15:0] dout;
  logic [15:0] env;
  logic [2:0]  state;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  adsr_envelope dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_tick          (tick),
    .i_gate          (gate),
    .i_attack_rate   (attack_rate),
    .i_decay_rate    (decay_rate),
    .i_sustain_level (sustain_level),
    .i_release_rate  (release_rate),
    .i_data          (din),
    .o_data          (dout),
    .o_env           (env),
    .o_state         (state),
    .o_busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        gate;
    logic        tick;
    logic [15:0] data;
    logic [2:0]  st;
    logic [15:0] env;
    logic [15:0] dout;
  } vec_t;

  vec_t vt [13];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h (%0d) expected 0x%h (%0d)", nm, act, act, exp, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string nm, input logic [2:0] st, input logic [15:0] e,
                         input logic [15:0] d);
    chk({nm, ".state"}, {13'd0, state}, {13'd0, st});
    chk({nm, ".env"}, env, e);
    chk({nm, ".data"}, dout, d);
    chk({nm, ".busy"}, {15'd0, busy}, {15'd0, (st != 3'd0)});
    $display("%s: state=%0d env=%0d data=%0d busy=%0d", nm, state, env, $signed(dout), busy);
  endtask

  task automatic set_rates();
    attack_rate   = 16'd16384;
    decay_rate    = 16'd8192;
    sustain_level = 16'd49152;
    release_rate  = 16'd16384;
  endtask

  initial begin
    // Gate held high through reset.
    rst = 1'b1; gate = 1'b1; tick = 1'b0; din = 16'd1000;
    set_rates();
    cyc(); cyc();
    chk_all("reset", 3'd0, 16'd0, 16'd0);
    rst = 1'b0;
    cyc();
    chk_all("post_reset", 3'd1, 16'd0, 16'd0);

    // Return to IDLE for the table run.
    rst = 1'b1; gate = 1'b0; din = 16'd16384;
    cyc();
    rst = 1'b0;
    cyc();
    chk_all("idle", 3'd0, 16'd0, 16'd0);

    // Full ADSR cycle, with a tick on every cycle. The input sample is
    // 16384, so each output is floor(previous env / 4).
    vt[0]  = '{1'b1, 1'b1, 16'd16384, 3'd1, 16'd0,     16'd0};
    vt[1]  = '{1'b1, 1'b1, 16'd16384, 3'd1, 16'd16384, 16'd0};
    vt[2]  = '{1'b1, 1'b1, 16'd16384, 3'd1, 16'd32768, 16'd4096};
    vt[3]  = '{1'b1, 1'b1, 16'd16384, 3'd1, 16'd49152, 16'd8192};
    vt[4]  = '{1'b1, 1'b1, 16'd16384, 3'd2, 16'd65535, 16'd12288};
    vt[5]  = '{1'b1, 1'b1, 16'd16384, 3'd2, 16'd57343, 16'd16383};
    vt[6]  = '{1'b1, 1'b1, 16'd16384, 3'd3, 16'd49152, 16'd14335};
    vt[7]  = '{1'b1, 1'b1, 16'd16384, 3'd3, 16'd49152, 16'd12288};
    vt[8]  = '{1'b0, 1'b1, 16'd16384, 3'd4, 16'd49152, 16'd12288};
    vt[9]  = '{1'b0, 1'b1, 16'd16384, 3'd4, 16'd32768, 16'd12288};
    vt[10] = '{1'b0, 1'b1, 16'd16384, 3'd4, 16'd16384, 16'd8192};
    vt[11] = '{1'b0, 1'b1, 16'd16384, 3'd0, 16'd0,     16'd4096};
    vt[12] = '{1'b0, 1'b0, 16'd16384, 3'd0, 16'd0,     16'd0};
    for (int i = 0; i < 13; i++) begin
      gate = vt[i].gate; tick = vt[i].tick; din = vt[i].data;
      cyc();
      chk_all($sformatf("adsr[%0d]", i), vt[i].st, vt[i].env, vt[i].dout);
    end

    // A gate fall together with a tick in ATTACK keeps the level.
    gate = 1'b1; tick = 1'b0; din = 16'd0;
    cyc();
    tick = 1'b1;
    cyc(); cyc();
    chk_all("attack_32768", 3'd1, 16'd32768, 16'd0);
    gate = 1'b0; tick = 1'b1;
    cyc();
    chk_all("collision", 3'd4, 16'd32768, 16'd0);

    // A retrigger in RELEASE continues the attack from the current level.
    gate = 1'b1; tick = 1'b1;
    cyc();
    chk_all("retrig", 3'd1, 16'd32768, 16'd0);
    cyc();
    chk_all("retrig_tick", 3'd1, 16'd49152, 16'd0);

    // Reach full scale, then hold it in DECAY with a zero decay rate.
    decay_rate = 16'd0;
    cyc();
    chk_all("full_scale", 3'd2, 16'd65535, 16'd0);
    tick = 1'b0; din = 16'd16384;
    cyc();
    chk_all("vca_pos", 3'd2, 16'd65535, 16'd16383);
    din = 16'hC000;
    cyc();
    chk_all("vca_neg", 3'd2, 16'd65535, 16'hC000);
    // Release step 32767 takes 65535 to 32768.
    gate = 1'b0; din = 16'd0;
    cyc();
    release_rate = 16'd32767; tick = 1'b1;
    cyc();
    chk_all("rel_32768", 3'd4, 16'd32768, 16'd0);
    tick = 1'b0; din = 16'hFFFD;
    cyc();
    chk_all("vca_m3", 3'd4, 16'd32768, 16'hFFFE);

    // A reset mid-note aborts at once, with the gate still high.
    gate = 1'b1; din = 16'd1000; rst = 1'b1;
    cyc();
    chk_all("reset_mid", 3'd0, 16'd0, 16'd0);
    rst = 1'b0;
    set_rates();
    cyc();
    chk_all("reset_mid_rel", 3'd1, 16'd0, 16'd0);

    // Live sustain tracking: reach SUSTAIN first, then change the level.
    din = 16'd0; tick = 1'b1;
    for (int i = 0; i < 6; i++) cyc();
    chk_all("sustain", 3'd3, 16'd49152, 16'd0);
    tick = 1'b0; sustain_level = 16'd20000;
    cyc();
    chk_all("sus_notick", 3'd3, 16'd49152, 16'd0);
    tick = 1'b1;
    cyc();
    chk_all("sus_live", 3'd3, 16'd20000, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/adsr_envelope.md
# adsr_envelope

Amplitude envelope generator and VCA sitting directly downstream of `square_wave`: takes its 16-bit sample stream on `i_data`, scales it by an ADSR (attack/decay/sustain/release) envelope driven by a note gate, and emits the shaped sample. The envelope advances once per sample tick. Single clock domain (5 MHz system clock).

## Interface
- No parameters; all widths fixed at 16 bits.

- `i_clk`  in  1  system clock; all logic on rising edge
- `i_rst`  in  1  reset, synchronous, active-high
- `i_tick`  in  1  sample-rate strobe, one cycle wide; envelope level updates only on ticks
- `i_gate`  in  1  note gate; high = key held
- `i_attack_rate`  in  16  unsigned level increment per tick in ATTACK
- `i_decay_rate`  in  16  unsigned level decrement per tick in DECAY
- `i_sustain_level`  in  16  unsigned sustain level
- `i_release_rate`  in  16  unsigned level decrement per tick in RELEASE
- `i_data`  in  16  signed two's-complement sample from `square_wave`
- `o_data`  out  16  signed shaped sample
- `o_env`  out  16  current envelope level, unsigned, 0..65535
- `o_state`  out  3  IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4
- `o_busy`  out  1  high whenever `o_state` != IDLE

## Operation
- Gate edge detection: register `gate_q` <= `i_gate`. Rise = `i_gate & ~gate_q`. Fall = `~i_gate & gate_q`.
- Transitions evaluated every clock. Gate events take priority over tick updates. A tick in the same cycle as a gate-caused transition is discarded, so the level is unchanged that cycle.
- IDLE: env = 0. Rise -> ATTACK.
- ATTACK, per tick: 17-bit sum = env + attack_rate. If sum >= 65535: env = 65535 and go to DECAY. Otherwise env = sum. Fall -> RELEASE.
- DECAY, per tick: if env <= sustain_level + decay_rate (17-bit compare): env = sustain_level and go to SUSTAIN. Otherwise env -= decay_rate. Fall -> RELEASE.
- SUSTAIN: on each tick env = `i_sustain_level`, so live changes are tracked at tick rate. Fall -> RELEASE.
- RELEASE, per tick: if env <= release_rate: env = 0 and go to IDLE. Otherwise env -= release_rate. Rise -> ATTACK, continuing from the current env (no reset to 0).
- Zero-rate cases:
  - attack_rate 0 never reaches 65535, so the envelope holds. Intended use: hold-at-level.
  - decay_rate 0 jumps to sustain on the first tick only if env <= sustain. Otherwise it holds.
  - release_rate 0 holds unless env is already 0.
- Rise during ATTACK, DECAY or SUSTAIN: ignored (no retrigger while held).
- VCA: `o_data` = (i_data × {1'b0, env}) >>> 16. This is a signed 16×17 multiply with an arithmetic shift, truncated toward −∞. The env used is the registered value at the start of the cycle.
- Full-scale env 65535 is not unity gain: +16384 -> +16383, −16384 -> −16384.

## Timing
- Reset (sync, `i_rst`=1 at a rising edge) clears all outputs and internal state on that edge:
  - `o_data`=0, `o_env`=0, `o_state`=IDLE, `o_busy`=0, `gate_q`=0.
  - Reset mid-note aborts immediately; no release phase.
- If `i_gate` is held high through reset, a rise is detected on the first edge after `i_rst` falls. ATTACK is visible one cycle after deassertion.
- Gate-to-state latency: `o_state` changes on the edge where the new `i_gate` value is first sampled, and is visible the following cycle.
- Tick-to-level latency: `o_env` updates on the edge sampling `i_tick`=1, and is visible the following cycle.
- Sample latency: `o_data` is registered, 1 cycle after `i_data`.
- The level change is reflected in `o_data` one cycle after `o_env` changes.
- `i_tick` high for consecutive cycles: each cycle counts as a tick. Legal, and used by the bench to compress time.

## Test plan
- Reset: assert `i_rst` with gate=1 and `i_data`=1000 -> all outputs 0, IDLE. Release reset -> ATTACK one cycle later, env still 0.
- Full ADSR with attack 16384, decay 8192, sustain 49152, release 16384, ticks every cycle:
  - attack: env 16384, 32768, 49152, then 65535 and DECAY
  - decay: 57343, then 49152 and SUSTAIN
  - gate low: RELEASE, then 32768, 16384, then 0 and IDLE
- Tick/gate collision: gate fall in the same cycle as a tick while in ATTACK at env 32768 -> RELEASE with env still 32768.
- Retrigger: gate rise in RELEASE at env 32768 with attack 16384 -> ATTACK, next tick env 49152 (not 16384).
- VCA arithmetic, env=65535: `i_data` +16384 -> `o_data` +16383, and −16384 -> −16384. With env=32768, `i_data`=−3 -> −2. Each result appears 1 cycle after the input.
- Live sustain: while in SUSTAIN change `i_sustain_level` 49152 -> 20000 -> env 20000 on the next tick and state stays SUSTAIN. Without a tick, env is unchanged.
